seq_alu: RTL and testbench

Parametrised, handshaked successor to the CPU's combinational ALU. Executes the existing logic/arithmetic/compare opcodes in one cycle, adds shifts and iterative multiply/divide, and owns a persistent flags register. Sits between the CPU control FSM and the register file; the control FSM issues operations with `start` and waits for `done`.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/seq_alu_if.sv | 27 ++
 rtl/alu_muldiv.sv | 83 ++++++++
 rtl/seq_alu.sv | 223 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and
// control FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  localparam int unsigned F_EQ   = 32'd0;
  localparam int unsigned F_GRT  = 32'd1;
  localparam int unsigned F_Z    = 32'd2;
  localparam int unsigned F_C    = 32'd3;
  localparam int unsigned F_N    = 32'd4;
  localparam int unsigned F_V    = 32'd5;
  localparam int unsigned F_DIV0 = 32'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the CPU control FSM (master) and the
// sequential ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic [7:0]       flags;

  modport master (
    output start, op, a, b,
    input  ready, done, res_lo, res_hi, flags
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, res_lo, res_hi, flags
  );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath,
// one bit per step; lo_nxt/hi_nxt show the value the current step produces.
module alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = {{(CW-1){1'b0}}, 1'b1};

  logic             mode_div_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;

  // acc holds the product high half (MUL) or partial remainder (DIV)
  assign add_s   = {1'b0, acc_r} + (q_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
  assign shl_s   = {acc_r, q_r[WIDTH-1]};
  assign trial_s = shl_s - {1'b0, b_r};

  // One iteration: shift-add for MUL, trial subtract and restore for DIV
  always_comb begin
    acc_nxt_s = acc_r;
    q_nxt_s   = q_r;
    if (mode_div_r) begin
      if (!trial_s[WIDTH]) begin
        acc_nxt_s = trial_s[WIDTH-1:0];
        q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = shl_s[WIDTH-1:0];
        q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = add_s[WIDTH:1];
      q_nxt_s   = {add_s[0], q_r[WIDTH-1:1]};
    end
  end

  // Operand capture on load, iteration state advance on step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_div_r <= 1'b0;
      acc_r      <= {WIDTH{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (load) begin
      mode_div_r <= is_div;
      acc_r      <= {WIDTH{1'b0}};
      q_r        <= a;
      b_r        <= b;
      cnt_r      <= CNT_INIT;
    end else if (step) begin
      acc_r      <= acc_nxt_s;
      q_r        <= q_nxt_s;
      cnt_r      <= cnt_r - CNT_LAST;
    end
  end

  assign last   = (cnt_r == CNT_LAST);
  assign lo_nxt = q_nxt_s;
  assign hi_nxt = acc_nxt_s;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops, optional
// iterative MUL/DIV, and a persistent flags register.
module seq_alu #(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_alu_if.slave bus
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ready_r;
  logic             done_r;
  logic [WIDTH-1:0] res_lo_r;
  logic [WIDTH-1:0] res_hi_r;
  logic [7:0]       flags_r;
  logic             is_div_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [WIDTH-1:0] alu_lo_s;
  logic [WIDTH-1:0] alu_hi_s;
  logic [7:0]       alu_flags_s;
  logic             upd_res_s;
  logic             zn_s;
  logic             multi_s;

  logic             md_load_s;
  logic             md_step_s;
  logic             md_last_s;
  logic [WIDTH-1:0] md_lo_s;
  logic [WIDTH-1:0] md_hi_s;
  logic [7:0]       md_flags_s;
  logic             lat_alu_s;
  logic             lat_md_s;

  assign sum_s   = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif_s   = {1'b0, bus.a} - {1'b0, bus.b};
  // Divide by zero completes in one cycle, so it never enters the iterator
  assign multi_s = MULDIV_EN && ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && (|bus.b)));

  // Single-cycle result and flag update for the opcode presented on the bus
  always_comb begin
    alu_lo_s    = bus.a;
    alu_hi_s    = {WIDTH{1'b0}};
    alu_flags_s = flags_r;
    upd_res_s   = 1'b1;
    zn_s        = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_lo_s         = sum_s[MSB:0];
        alu_flags_s[F_C] = sum_s[WIDTH];
        alu_flags_s[F_V] = (bus.a[MSB] == bus.b[MSB]) && (sum_s[MSB] != bus.a[MSB]);
        zn_s             = 1'b1;
      end
      OP_SUB: begin
        alu_lo_s         = dif_s[MSB:0];
        alu_flags_s[F_C] = dif_s[WIDTH];
        alu_flags_s[F_V] = (bus.a[MSB] != bus.b[MSB]) && (dif_s[MSB] != bus.a[MSB]);
        zn_s             = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (bus.op)
          OP_AND:  alu_lo_s = bus.a & bus.b;
          OP_OR:   alu_lo_s = bus.a | bus.b;
          OP_XOR:  alu_lo_s = bus.a ^ bus.b;
          default: alu_lo_s = ~bus.a;
        endcase
        alu_flags_s[F_C] = 1'b0;
        alu_flags_s[F_V] = 1'b0;
        zn_s             = 1'b1;
      end
      OP_CMP: begin
        upd_res_s          = 1'b0;
        alu_flags_s[F_EQ]  = (bus.a == bus.b);
        alu_flags_s[F_GRT] = (bus.a > bus.b);
      end
      OP_SHL: begin
        alu_lo_s         = {bus.a[MSB-1:0], 1'b0};
        alu_flags_s[F_C] = bus.a[MSB];
        alu_flags_s[F_V] = 1'b0;
        zn_s             = 1'b1;
      end
      OP_SHR: begin
        alu_lo_s         = {1'b0, bus.a[MSB:1]};
        alu_flags_s[F_C] = bus.a[0];
        alu_flags_s[F_V] = 1'b0;
        zn_s             = 1'b1;
      end
      OP_DIV: begin
        if (MULDIV_EN) begin
          alu_lo_s            = {WIDTH{1'b1}};
          alu_hi_s            = bus.a;
          alu_flags_s[F_Z]    = 1'b0;
          alu_flags_s[F_C]    = 1'b0;
          alu_flags_s[F_V]    = 1'b0;
          alu_flags_s[F_DIV0] = 1'b1;
        end else begin
          alu_lo_s = bus.a;
        end
      end
      default: begin
        alu_lo_s = bus.a;
      end
    endcase
    alu_flags_s[F_Z] = zn_s ? ~|alu_lo_s : alu_flags_s[F_Z];
    alu_flags_s[F_N] = zn_s ? alu_lo_s[MSB] : alu_flags_s[F_N];
  end

  // Flags for a completed MUL/DIV, taken from the final iteration's values
  always_comb begin
    md_flags_s         = flags_r;
    md_flags_s[F_C]    = 1'b0;
    md_flags_s[F_V]    = 1'b0;
    if (is_div_r) begin
      md_flags_s[F_Z]    = ~|md_lo_s;
      md_flags_s[F_DIV0] = 1'b0;
    end else begin
      md_flags_s[F_Z]    = ~|{md_hi_s, md_lo_s};
      md_flags_s[F_N]    = md_hi_s[MSB];
      md_flags_s[F_C]    = |md_hi_s;
    end
  end

  // Control FSM next state and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    md_load_s   = 1'b0;
    md_step_s   = 1'b0;
    lat_alu_s   = 1'b0;
    lat_md_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (multi_s) begin
            md_load_s   = 1'b1;
            state_nxt_s = ST_BUSY;
          end else begin
            lat_alu_s   = 1'b1;
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        md_step_s = 1'b1;
        if (md_last_s) begin
          lat_md_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, handshake outputs and architectural result/flags registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      res_lo_r <= {WIDTH{1'b0}};
      res_hi_r <= {WIDTH{1'b0}};
      flags_r  <= 8'h00;
      is_div_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if (md_load_s) begin
        is_div_r <= (bus.op == OP_DIV);
      end
      if (lat_alu_s) begin
        if (upd_res_s) begin
          res_lo_r <= alu_lo_s;
          res_hi_r <= alu_hi_s;
        end
        flags_r <= {1'b0, alu_flags_s[6:0]};
      end else if (lat_md_s) begin
        res_lo_r <= md_lo_s;
        res_hi_r <= md_hi_s;
        flags_r  <= {1'b0, md_flags_s[6:0]};
      end
    end
  end

  generate
    if (MULDIV_EN) begin : g_md
      alu_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (md_load_s),
        .step   (md_step_s),
        .is_div (bus.op == OP_DIV),
        .a      (bus.a),
        .b      (bus.b),
        .last   (md_last_s),
        .lo_nxt (md_lo_s),
        .hi_nxt (md_hi_s)
      );
    end else begin : g_no_md
      assign md_last_s = 1'b0;
      assign md_lo_s   = {WIDTH{1'b0}};
      assign md_hi_s   = {WIDTH{1'b0}};
    end
  endgenerate

  assign bus.ready  = ready_r;
  assign bus.done   = done_r;
  assign bus.res_lo = res_lo_r;
  assign bus.res_hi = res_hi_r;
  assign bus.flags  = flags_r;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: randomized and directed operations checked
// against an arithmetic reference model, plus a MULDIV_EN=0 instance.
module tb_seq_alu;

  localparam int W = 8;

  typedef struct {
    int       lo;
    int       hi;
    bit [7:0] fl;
    int       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst0_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int       m_lo, m_hi, m0_lo, m0_hi;
  bit [7:0] m_fl, m0_fl;
  bit       prev_done = 1'b0;
  bit       d0_finished = 1'b0;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu_if #(.WIDTH(W)) bus0 ();

  seq_alu #(.WIDTH(W), .MULDIV_EN(1'b1)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  seq_alu #(.WIDTH(W), .MULDIV_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results and flags straight from the opcode definitions
  task automatic model(input bit en, input int op, input int a, input int b,
                       inout int lo, inout int hi, inout bit [7:0] fl, output bit multi);
    int mask = (1 << W) - 1;
    int msb  = 1 << (W - 1);
    int r;
    bit zn = 1'b0;
    multi = 1'b0;
    case (op)
      0: begin r = a + b; lo = r & mask; hi = 0; fl[3] = (r > mask);
               fl[5] = ((a & msb) == (b & msb)) && ((lo & msb) != (a & msb)); zn = 1'b1; end
      1: begin lo = (a - b) & mask; hi = 0; fl[3] = (a < b);
               fl[5] = ((a & msb) != (b & msb)) && ((lo & msb) != (a & msb)); zn = 1'b1; end
      2, 3, 4, 5: begin
        lo = (op == 2) ? (a & b) : (op == 3) ? (a | b) : (op == 4) ? (a ^ b) : (~a & mask);
        hi = 0; fl[3] = 1'b0; fl[5] = 1'b0; zn = 1'b1;
      end
      6: begin fl[0] = (a == b); fl[1] = (a > b); end
      7: begin lo = (a << 1) & mask; hi = 0; fl[3] = ((a & msb) != 0); fl[5] = 1'b0; zn = 1'b1; end
      8: begin lo = a >> 1; hi = 0; fl[3] = ((a & 1) != 0); fl[5] = 1'b0; zn = 1'b1; end
      9: begin
        if (en) begin
          r = a * b; lo = r & mask; hi = r >> W; multi = 1'b1;
          fl[2] = (r == 0); fl[4] = ((hi & msb) != 0); fl[3] = (hi != 0); fl[5] = 1'b0;
        end else begin lo = a; hi = 0; end
      end
      10: begin
        if (en && b == 0) begin
          lo = mask; hi = a; fl[2] = 1'b0; fl[3] = 1'b0; fl[5] = 1'b0; fl[6] = 1'b1;
        end else if (en) begin
          lo = a / b; hi = a % b; multi = 1'b1;
          fl[2] = (lo == 0); fl[3] = 1'b0; fl[5] = 1'b0; fl[6] = 1'b0;
        end else begin lo = a; hi = 0; end
      end
      default: begin lo = a; hi = 0; end
    endcase
    if (zn) begin
      fl[2] = (lo == 0);
      fl[4] = ((lo & msb) != 0);
    end
  endtask

  // Drive one request when the DUT is idle; optionally leave start asserted
  task automatic issue(input int op, input int a, input int b, input bit hold);
    int   n = 0;
    bit   multi;
    exp_t e;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_wait_ready", int'(bus.ready === 1'b1), 1);
    bus.start = 1'b1;
    bus.op    = 4'(op);
    bus.a     = W'(a);
    bus.b     = W'(b);
    model(1'b1, op, a, b, m_lo, m_hi, m_fl, multi);
    e.lo  = m_lo;
    e.hi  = m_hi;
    e.fl  = m_fl;
    e.cyc = cyc + 1 + (multi ? W : 0);
    sb.push_back(e);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  function automatic int rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 255;
      2:       return 128;
      3:       return 1;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("res_lo", int'(bus.res_lo), e.lo);
        chk("res_hi", int'(bus.res_hi), e.hi);
        chk("flags", int'(bus.flags), int'(e.fl));
        chk("done_cycle", cyc, e.cyc);
        chk("ready_in_done", int'(bus.ready), 0);
      end
    end
    if (prev_done) begin
      chk("ready_after_done", int'(bus.ready), 1);
      chk("done_single_pulse", int'(bus.done), 0);
    end
    prev_done = (bus.done === 1'b1);
  end

  // Main stimulus against the MULDIV_EN=1 instance
  initial begin
    int n;
    bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    m_lo = 0; m_hi = 0; m_fl = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_res_lo", int'(bus.res_lo), 0);
    chk("rst_res_hi", int'(bus.res_hi), 0);
    chk("rst_flags", int'(bus.flags), 0);

    issue(0, 8'hF0, 8'h20, 1'b0);
    issue(1, 8'h80, 8'h01, 1'b0);
    issue(6, 8'h05, 8'h05, 1'b0);
    issue(9, 8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd0; bus.a = 8'h11; bus.b = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    issue(10, 200, 7, 1'b0);
    issue(10, 8'h2A, 0, 1'b0);
    issue(6, 8'h50, 8'h10, 1'b0);
    issue(13, 8'h3C, 8'h11, 1'b0);
    issue(7, 8'h81, 8'h00, 1'b0);
    issue(8, 8'h01, 8'h00, 1'b0);
    issue(10, 8'h05, 8'h09, 1'b0);

    for (int i = 0; i < 8; i++) issue(int'($urandom_range(0, 8)), rnd_operand(), rnd_operand(), 1'b1);
    issue(9, 8'h10, 8'h10, 1'b1);
    issue(2, 8'hF0, 8'h0F, 1'b0);

    // Reset in the middle of a multiply: the operation must vanish
    issue(9, 8'h37, 8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    m_lo = 0; m_hi = 0; m_fl = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", int'(bus.ready), 1);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_res_lo", int'(bus.res_lo), 0);
    chk("midrst_res_hi", int'(bus.res_hi), 0);
    chk("midrst_flags", int'(bus.flags), 0);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 150; i++)
      issue(int'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), bit'($urandom_range(0, 1)));
    bus.start = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    n = 0;
    while (!d0_finished && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("nomd_finished", int'(d0_finished), 1);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic do0(input int op, input int a, input int b);
    bit multi;
    chk("nomd_ready", int'(bus0.ready), 1);
    bus0.start = 1'b1;
    bus0.op    = 4'(op);
    bus0.a     = W'(a);
    bus0.b     = W'(b);
    model(1'b0, op, a, b, m0_lo, m0_hi, m0_fl, multi);
    @(negedge clk);
    bus0.start = 1'b0;
    chk("nomd_done", int'(bus0.done), 1);
    chk("nomd_res_lo", int'(bus0.res_lo), m0_lo);
    chk("nomd_res_hi", int'(bus0.res_hi), m0_hi);
    chk("nomd_flags", int'(bus0.flags), int'(m0_fl));
    @(negedge clk);
  endtask

  // Directed sequence for the build without MUL/DIV hardware
  initial begin
    bus0.start = 1'b0; bus0.op = 4'd0; bus0.a = '0; bus0.b = '0;
    m0_lo = 0; m0_hi = 0; m0_fl = 8'h00;
    rst0_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0_n = 1'b1;
    do0(6, 8'h50, 8'h10);
    do0(13, 8'h3C, 8'h11);
    do0(9, 8'h3C, 8'h05);
    do0(10, 8'h3C, 8'h00);
    do0(0, 8'h7F, 8'h01);
    d0_finished = 1'b1;
  end

endmodule
